// File: rtl/bp_fpga_host_nbf_rx.sv
// FPGA host bridge receive path: UART bytes -> NBF packets -> single-beat uncached IO commands.
// IO header layout (LSB first): msg_type[3:0], addr[paddr_width_p], size[2:0], payload (zero on commands).
module bp_fpga_host_nbf_rx
  #(parameter int paddr_width_p      = 40
  , parameter int nbf_addr_width_p   = paddr_width_p
  , parameter int nbf_data_width_p   = 64
  , parameter int uart_data_bits_p   = 8
  , parameter int nbf_buffer_els_p   = 4
  , parameter int io_credits_p       = 16
  , parameter int io_payload_width_p = 17
  , localparam int io_header_width_lp = 4 + paddr_width_p + 3 + io_payload_width_p
  , localparam int nbf_width_lp       = 8 + nbf_addr_width_p + nbf_data_width_p
  , localparam int nbf_bytes_lp       = nbf_width_lp / 8
  )
  (input  logic                          clk_i
  , input  logic                          reset_i
  , input  logic [uart_data_bits_p-1:0]   rx_i
  , input  logic                          rx_v_i
  , output logic [io_header_width_lp-1:0] io_cmd_header_o
  , output logic [nbf_data_width_p-1:0]   io_cmd_data_o
  , output logic                          io_cmd_v_o
  , input  logic                          io_cmd_ready_and_i
  , output logic                          io_cmd_last_o
  , input  logic [io_header_width_lp-1:0] io_resp_header_i
  , input  logic [nbf_data_width_p-1:0]   io_resp_data_i
  , input  logic                          io_resp_v_i
  , output logic                          io_resp_ready_and_o
  , input  logic                          io_resp_last_i
  , output logic [nbf_width_lp-1:0]       nbf_o
  , output logic                          nbf_v_o
  , input  logic                          nbf_ready_and_i
  , output logic                          overflow_o
  );

  localparam int cnt_width_lp  = $clog2(nbf_bytes_lp);
  localparam int ptr_width_lp  = (nbf_buffer_els_p > 1) ? $clog2(nbf_buffer_els_p) : 1;
  localparam int fcnt_width_lp = $clog2(nbf_buffer_els_p + 1);
  localparam int cred_width_lp = $clog2(io_credits_p + 1);

  localparam logic [7:0] op_write_8_lp = 8'h03;
  localparam logic [7:0] op_read_8_lp  = 8'h13;
  localparam logic [7:0] op_fence_lp   = 8'hFE;
  localparam logic [7:0] op_finish_lp  = 8'hFF;

  localparam logic [3:0] msg_uc_rd_lp  = 4'd2;
  localparam logic [3:0] msg_uc_wr_lp  = 4'd3;
  localparam logic [2:0] msg_size_8_lp = 3'd3;

  typedef enum logic [2:0] {e_reset, e_ready, e_read_wait, e_drain, e_send_nbf} state_e;

  state_e state_q, state_d;

  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [nbf_width_lp-1:0]  asm_q, asm_d;
  logic [ptr_width_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [fcnt_width_lp-1:0] fcnt_q, fcnt_d;
  logic [cred_width_lp-1:0] credits_q, credits_d;
  logic [nbf_width_lp-1:0]  saved_q, saved_d;
  logic                     overflow_q, overflow_d;
  logic [nbf_width_lp-1:0]  fifo_mem [nbf_buffer_els_p];

  logic                        last_byte, push, pop, fifo_full, fifo_empty;
  logic                        cmd_hs, resp_hs, credits_avail;
  logic [nbf_width_lp-1:0]     head;
  logic [7:0]                  head_op;
  logic [nbf_addr_width_p-1:0] head_addr;
  logic [nbf_data_width_p-1:0] head_data;
  logic [3:0]                  cmd_msg_type;

  // Deserializer: bytes shift in from the top so the opcode ends up in the low byte.
  assign last_byte = rx_v_i && (cnt_q == cnt_width_lp'(nbf_bytes_lp - 1));

  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (rx_v_i) begin
      asm_d = {rx_i, asm_q[nbf_width_lp-1:uart_data_bits_p]};
      cnt_d = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  assign fifo_full  = (fcnt_q == fcnt_width_lp'(nbf_buffer_els_p));
  assign fifo_empty = (fcnt_q == '0);
  assign push       = last_byte && !fifo_full;
  assign overflow_d = overflow_q | (last_byte & fifo_full);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (push) wptr_d = (wptr_q == ptr_width_lp'(nbf_buffer_els_p - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == ptr_width_lp'(nbf_buffer_els_p - 1)) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= asm_d;
  end

  assign head      = fifo_mem[rptr_q];
  assign head_op   = head[7:0];
  assign head_addr = head[8 +: nbf_addr_width_p];
  assign head_data = head[8 + nbf_addr_width_p +: nbf_data_width_p];

  // Credits bound the number of commands awaiting a response.
  assign cmd_hs        = io_cmd_v_o & io_cmd_ready_and_i;
  assign resp_hs       = io_resp_v_i & io_resp_ready_and_o;
  assign credits_avail = (credits_q < cred_width_lp'(io_credits_p));

  always_comb begin
    credits_d = credits_q;
    case ({cmd_hs, resp_hs})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = (credits_q != '0) ? credits_q - 1'b1 : credits_q;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    pop           = 1'b0;
    io_cmd_v_o    = 1'b0;
    io_cmd_data_o = '0;
    cmd_msg_type  = msg_uc_wr_lp;
    nbf_v_o       = 1'b0;
    case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        if (!fifo_empty) begin
          case (head_op)
            op_write_8_lp: begin
              io_cmd_v_o    = credits_avail;
              io_cmd_data_o = head_data;
              pop           = credits_avail && io_cmd_ready_and_i;
            end
            op_read_8_lp: begin
              io_cmd_v_o   = credits_avail;
              cmd_msg_type = msg_uc_rd_lp;
              if (credits_avail && io_cmd_ready_and_i) begin
                pop     = 1'b1;
                saved_d = head;
                state_d = e_read_wait;
              end
            end
            op_fence_lp, op_finish_lp: begin
              pop     = 1'b1;
              saved_d = head;
              state_d = e_drain;
            end
            default: pop = 1'b1;
          endcase
        end
      end
      e_read_wait: begin
        if (io_resp_v_i && (io_resp_header_i[3:0] == msg_uc_rd_lp)) begin
          saved_d = {io_resp_data_i, saved_q[8 + nbf_addr_width_p - 1:0]};
          state_d = e_send_nbf;
        end
      end
      e_drain: begin
        if ((credits_q == '0) && !io_resp_v_i) state_d = e_send_nbf;
      end
      e_send_nbf: begin
        nbf_v_o = 1'b1;
        if (nbf_ready_and_i) state_d = e_ready;
      end
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
      credits_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    asm_q   <= asm_d;
    saved_q <= saved_d;
  end

  assign io_cmd_header_o     = {{io_payload_width_p{1'b0}}, msg_size_8_lp,
                                head_addr[paddr_width_p-1:0], cmd_msg_type};
  assign io_cmd_last_o       = io_cmd_v_o;
  assign io_resp_ready_and_o = 1'b1;
  assign nbf_o               = saved_q;
  assign overflow_o          = overflow_q;

  logic unused_ok;
  assign unused_ok = ^{io_resp_header_i[io_header_width_lp-1:4], io_resp_last_i};

  resp_needs_credit_a: assert property (@(posedge clk_i) disable iff (reset_i)
    io_resp_v_i |-> (credits_q != '0));

endmodule

// File: tb/tb_bp_fpga_host_nbf_rx.sv
// Directed and randomized bench for bp_fpga_host_nbf_rx with two IO credits and a 4-deep packet FIFO.
module tb_bp_fpga_host_nbf_rx;

  localparam logic [7:0] OP_W   = 8'h03;
  localparam logic [7:0] OP_R   = 8'h13;
  localparam logic [7:0] OP_FEN = 8'hFE;
  localparam logic [7:0] OP_FIN = 8'hFF;
  localparam logic [3:0] MT_RD  = 4'd2;
  localparam logic [3:0] MT_WR  = 4'd3;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [7:0]   rx_i;
  logic         rx_v_i;
  logic [63:0]  io_cmd_header_o;
  logic [63:0]  io_cmd_data_o;
  logic         io_cmd_v_o;
  logic         io_cmd_ready_and_i;
  logic         io_cmd_last_o;
  logic [63:0]  io_resp_header_i;
  logic [63:0]  io_resp_data_i;
  logic         io_resp_v_i;
  logic         io_resp_ready_and_o;
  logic         io_resp_last_i;
  logic [111:0] nbf_o;
  logic         nbf_v_o;
  logic         nbf_ready_and_i;
  logic         overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] cmd_q[$];
  logic [111:0] nbf_q[$];

  bp_fpga_host_nbf_rx #(.io_credits_p(2), .nbf_buffer_els_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .rx_v_i(rx_v_i),
    .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o),
    .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_cmd_last_o(io_cmd_last_o), .io_resp_header_i(io_resp_header_i),
    .io_resp_data_i(io_resp_data_i), .io_resp_v_i(io_resp_v_i),
    .io_resp_ready_and_o(io_resp_ready_and_o), .io_resp_last_i(io_resp_last_i),
    .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
    .overflow_o(overflow_o));

  always #5 clk = ~clk;

  // Record handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (io_cmd_v_o && io_cmd_ready_and_i) cmd_q.push_back({io_cmd_header_o, io_cmd_data_o});
      if (nbf_v_o && nbf_ready_and_i) nbf_q.push_back(nbf_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_hdr(input logic [3:0] mt, input logic [39:0] a);
    return {17'b0, 3'd3, a, mt};
  endfunction

  function automatic logic [39:0] rand_addr();
    return {8'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [63:0] rand_data();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_i   = b;
    rx_v_i = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
    logic [111:0] p;
    p = {d, a, op};
    for (int i = 0; i < 14; i++) send_byte(p[i*8 +: 8]);
    rx_v_i = 1'b0;
  endtask

  task automatic send_resp(input logic [3:0] mt, input logic [63:0] d);
    io_resp_header_i = {60'b0, mt};
    io_resp_data_i   = d;
    io_resp_v_i      = 1'b1;
    tick();
    io_resp_v_i      = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input logic [3:0] mt, input logic [39:0] a,
                            input logic [63:0] d);
    logic [127:0] e;
    int waited = 0;
    while (cmd_q.size() == 0 && waited < 60) begin
      tick();
      waited++;
    end
    chk({tag, "_present"}, (cmd_q.size() > 0), 1);
    if (cmd_q.size() > 0) begin
      e = cmd_q.pop_front();
      chk({tag, "_hdr"}, e[127:64], exp_hdr(mt, a));
      chk({tag, "_data"}, e[63:0], d);
      $display("cmd %s: hdr=%0h data=%0h", tag, e[127:64], e[63:0]);
    end
  endtask

  task automatic expect_nbf(input string tag, input logic [111:0] exp);
    logic [111:0] e;
    int waited = 0;
    while (nbf_q.size() == 0 && waited < 60) begin
      tick();
      waited++;
    end
    chk({tag, "_present"}, (nbf_q.size() > 0), 1);
    if (nbf_q.size() > 0) begin
      e = nbf_q.pop_front();
      chk({tag, "_pkt"}, e, exp);
      $display("nbf %s: %0h", tag, e);
    end
  endtask

  initial begin
    logic [39:0] wa[5];
    logic [63:0] wd[5];
    logic [39:0] fa;
    logic [63:0] fd, rd;
    logic [7:0]  op;
    int          early;

    reset_i = 1'b1; rx_i = 8'h0; rx_v_i = 1'b0;
    io_cmd_ready_and_i = 1'b0; io_resp_header_i = '0; io_resp_data_i = '0;
    io_resp_v_i = 1'b0; io_resp_last_i = 1'b0; nbf_ready_and_i = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_v", io_cmd_v_o, 0);
    chk("rst_nbf_v", nbf_v_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_resp_ready", io_resp_ready_and_o, 1);
    reset_i = 1'b0;
    tick();
    chk("idle_cmd_v", io_cmd_v_o, 0);
    chk("idle_nbf_v", nbf_v_o, 0);

    // Single write
    io_cmd_ready_and_i = 1'b1;
    send_pkt(OP_W, 40'h80000000, 64'hDEADBEEF01234567);
    chk("t1_latency", io_cmd_v_o, 1);
    chk("t1_last", io_cmd_last_o, 1);
    expect_cmd("t1", MT_WR, 40'h80000000, 64'hDEADBEEF01234567);
    repeat (5) tick();
    chk("t1_single", cmd_q.size(), 0);
    send_resp(MT_WR, '0);

    // Fence after three writes; only two credits exist
    for (int i = 0; i < 3; i++) begin
      wa[i] = rand_addr(); wd[i] = rand_data();
      send_pkt(OP_W, wa[i], wd[i]);
    end
    fa = rand_addr(); fd = rand_data();
    send_pkt(OP_FEN, fa, fd);
    early = 0;
    repeat (20) begin
      tick();
      if (nbf_v_o) early++;
    end
    chk("t2_cmds_before_resp", cmd_q.size(), 2);
    chk("t2_cmd_stalled", io_cmd_v_o, 0);
    send_resp(MT_WR, '0);
    for (int i = 0; i < 3; i++) expect_cmd($sformatf("t2_w%0d", i), MT_WR, wa[i], wd[i]);
    send_resp(MT_WR, '0);
    chk("t2_nbf_after_resp2", nbf_v_o, 0);
    send_resp(MT_WR, '0);
    chk("t2_nbf_after_resp3", nbf_v_o, 0);
    tick();
    chk("t2_nbf_rise", nbf_v_o, 1);
    chk("t2_nbf_pkt", nbf_o, {fd, fa, OP_FEN});
    chk("t2_no_early_nbf", early, 0);
    repeat (2) tick();
    chk("t2_nbf_hold", nbf_o, {fd, fa, OP_FEN});
    nbf_ready_and_i = 1'b1;
    tick();
    nbf_ready_and_i = 1'b0;
    chk("t2_nbf_done", nbf_v_o, 0);
    expect_nbf("t2", {fd, fa, OP_FEN});

    // Read
    rd = rand_data();
    send_pkt(OP_R, 40'h80000008, rd);
    expect_cmd("t3", MT_RD, 40'h80000008, 64'h0);
    repeat (3) tick();
    chk("t3_nbf_wait", nbf_v_o, 0);
    send_resp(MT_RD, 64'h55);
    chk("t3_nbf_rise", nbf_v_o, 1);
    chk("t3_nbf_pkt", nbf_o, {64'h55, 40'h80000008, OP_R});
    nbf_ready_and_i = 1'b1;
    tick();
    nbf_ready_and_i = 1'b0;
    chk("t3_nbf_done", nbf_v_o, 0);
    expect_nbf("t3", {64'h55, 40'h80000008, OP_R});

    // Credit limit
    for (int i = 0; i < 3; i++) begin
      wa[i] = rand_addr(); wd[i] = rand_data();
      send_pkt(OP_W, wa[i], wd[i]);
    end
    repeat (5) tick();
    chk("t4_two_issued", cmd_q.size(), 2);
    chk("t4_cmd_dropped", io_cmd_v_o, 0);
    send_resp(MT_WR, '0);
    chk("t4_cmd_resume", io_cmd_v_o, 1);
    tick();
    chk("t4_three_issued", cmd_q.size(), 3);
    for (int i = 0; i < 3; i++) expect_cmd($sformatf("t4_w%0d", i), MT_WR, wa[i], wd[i]);
    send_resp(MT_WR, '0);
    send_resp(MT_WR, '0);

    // Overflow
    io_cmd_ready_and_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wa[i] = rand_addr(); wd[i] = rand_data();
      send_pkt(OP_W, wa[i], wd[i]);
    end
    chk("t5_overflow", overflow_o, 1);
    chk("t5_head_valid", io_cmd_v_o, 1);
    io_cmd_ready_and_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_cmd($sformatf("t5_w%0d", i), MT_WR, wa[i], wd[i]);
      send_resp(MT_WR, '0);
    end
    repeat (20) tick();
    chk("t5_exactly4", cmd_q.size(), 0);
    chk("t5_sticky", overflow_o, 1);

    // Reset mid-packet
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    rx_v_i = 1'b0;
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    chk("t6_overflow_clr", overflow_o, 0);
    fa = rand_addr(); fd = rand_data();
    nbf_ready_and_i = 1'b1;
    send_pkt(OP_FEN, fa, fd);
    expect_nbf("t6", {fd, fa, OP_FEN});
    repeat (5) tick();
    chk("t6_no_cmd", cmd_q.size(), 0);

    // Randomized packets checked against opcode rules
    for (int k = 0; k < 10; k++) begin
      fa = rand_addr(); fd = rand_data();
      case ($urandom_range(0, 3))
        0: op = OP_W;
        1: op = OP_R;
        2: op = OP_FIN;
        default: op = 8'h20 + 8'($urandom_range(0, 15));
      endcase
      send_pkt(op, fa, fd);
      if (op == OP_W) begin
        expect_cmd($sformatf("r%0d_wr", k), MT_WR, fa, fd);
        send_resp(MT_WR, rand_data());
      end else if (op == OP_R) begin
        expect_cmd($sformatf("r%0d_rd", k), MT_RD, fa, 64'h0);
        rd = rand_data();
        send_resp(MT_RD, rd);
        expect_nbf($sformatf("r%0d_rd", k), {rd, fa, OP_R});
      end else if (op == OP_FIN) begin
        expect_nbf($sformatf("r%0d_fin", k), {fd, fa, OP_FIN});
      end else begin
        repeat (30) tick();
        chk($sformatf("r%0d_drop_cmd", k), cmd_q.size(), 0);
        chk($sformatf("r%0d_drop_nbf", k), nbf_q.size(), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
